seg7_pattern_decoder: RTL

//  - Receive end of the 7-segment display path: samples an active-low segment bus hex[6:0],

---
 rtl/seg7_pkg.sv | 25 ++
 rtl/seg7_pattern_lut.sv | 18 +
 rtl/seg7_pattern_decoder.sv | 73 +++++++
 3 files changed

// File: rtl/seg7_pkg.sv
// seg7_pkg: shared 7-segment pattern table (active-low, bit0=a..bit6=g) and decoder state encoding.
package seg7_pkg;
    localparam logic [6:0] SEG_0 = 7'h40;
    localparam logic [6:0] SEG_1 = 7'h79;
    localparam logic [6:0] SEG_2 = 7'h24;
    localparam logic [6:0] SEG_3 = 7'h30;
    localparam logic [6:0] SEG_4 = 7'h19;
    localparam logic [6:0] SEG_5 = 7'h12;
    localparam logic [6:0] SEG_6 = 7'h02;
    localparam logic [6:0] SEG_7 = 7'h78;
    localparam logic [6:0] SEG_8 = 7'h00;
    localparam logic [6:0] SEG_9 = 7'h10;
    localparam logic [6:0] SEG_A = 7'h08;
    localparam logic [6:0] SEG_B = 7'h03;
    localparam logic [6:0] SEG_C = 7'h46;
    localparam logic [6:0] SEG_D = 7'h21;
    localparam logic [6:0] SEG_E = 7'h06;
    localparam logic [6:0] SEG_F = 7'h0E;
    localparam logic [6:0] SEG_BLANK = 7'h7F;
    localparam logic [15:0][6:0] SEG_TABLE = {SEG_F, SEG_E, SEG_D, SEG_C, SEG_B, SEG_A, SEG_9, SEG_8,
                                              SEG_7, SEG_6, SEG_5, SEG_4, SEG_3, SEG_2, SEG_1, SEG_0};
    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_SETTLE = 2'd1;
    localparam logic [1:0] ST_LOCKED = 2'd2;
endpackage

// File: rtl/seg7_pattern_lut.sv
// seg7_pattern_lut: reverse lookup of a segment pattern to its hex nibble, hit=0 when not in the table.
module seg7_pattern_lut
    import seg7_pkg::*;
(
    input  logic [6:0] seg,
    output logic       hit,
    output logic [3:0] nibble
);
    always_comb begin
        hit = 1'b0;
        nibble = 4'd0;
        for (int i = 0; i < 16; i++)
            if (seg == SEG_TABLE[i]) begin
                hit = 1'b1;
                nibble = 4'(i);
            end
    end
endmodule

// File: rtl/seg7_pattern_decoder.sv
// seg7_pattern_decoder: debounces an active-low 7-segment bus and decodes it to a digit with status.
// Optional SEG7_BLANK_DETECT_EN: accept the all-off pattern as blank instead of flagging it illegal.
module seg7_pattern_decoder
    import seg7_pkg::*;
#(
    parameter int STABLE_CYCLES = 4,
    parameter int ERR_W = 8
) (
    input  logic             clock,
    input  logic             resetn,
    input  logic [6:0]       seg_in,
    input  logic             err_clr,
    output logic [3:0]       digit,
    output logic             valid,
    output logic             changed,
    output logic             err,
    output logic             blank,
    output logic [ERR_W-1:0] err_count
);
    localparam int CW = $clog2(STABLE_CYCLES + 1);
    localparam logic [CW-1:0] STABLE = CW'(STABLE_CYCLES);

    logic [6:0]    samp, prev;
    logic [CW-1:0] cnt, cnt_nxt;
    logic [1:0]    state;
    logic          same, accept, hit, is_blank, bad;
    logic [3:0]    nibble;

    seg7_pattern_lut u_lut (.seg(samp), .hit(hit), .nibble(nibble));

    assign same = samp == prev;
    assign cnt_nxt = !same ? CW'(1) : (cnt == STABLE ? cnt : cnt + 1'b1);
    // a change edge itself may accept when only one stable sample is required
    assign accept = cnt_nxt == STABLE && (state == ST_SETTLE || !same);
    assign bad = accept && !hit && !is_blank;

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            samp <= SEG_BLANK;
            prev <= SEG_BLANK;
            cnt <= '0;
            state <= ST_IDLE;
            digit <= 4'd0;
            valid <= 1'b0;
            changed <= 1'b0;
            err <= 1'b0;
            err_count <= '0;
        end else begin
            samp <= seg_in;
            prev <= samp;
            cnt <= cnt_nxt;
            state <= accept ? ST_LOCKED : (!same ? ST_SETTLE : state);
            changed <= accept && hit && (!valid || nibble != digit);
            err <= bad;
            digit <= accept && hit ? nibble : digit;
            valid <= accept ? hit : valid;
            err_count <= err_clr ? '0 : (bad && !(&err_count)) ? err_count + 1'b1 : err_count;
        end
    end

`ifdef SEG7_BLANK_DETECT_EN
    assign is_blank = samp == SEG_BLANK;
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn)
            blank <= 1'b0;
        else if (accept)
            blank <= is_blank;
    end
`else
    assign is_blank = 1'b0;
    assign blank = 1'b0;
`endif
endmodule
